// File: rtl/ifetch_unit.sv
// Instruction fetch: one-outstanding imem requester feeding a FIFO to decode.
// Optional misaligned-PC trap via `IFETCH_MISALIGN_CHECK_EN (adds id_misalign_o).
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   pc_i, flush_i      PC register value, redirect/branch-taken
//   stall_o            PC register hold (low = advance or load target)
//   imem_*             request/grant/response to instruction memory
//   id_valid_o/ready_i head-of-buffer handshake to decode
//   id_inst_o, id_pc_o head instruction and its PC
module ifetch_unit #(
  parameter int BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        id_valid_o,
  input  logic        id_ready_i,
  output logic [31:0] id_inst_o,
`ifdef IFETCH_MISALIGN_CHECK_EN
  output logic [31:0] id_pc_o,
  output logic        id_misalign_o
`else
  output logic [31:0] id_pc_o
`endif
);

  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_DISCARD
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0] count_q;
  logic [PW-1:0] rd_q, wr_q;
  logic [31:0]   pend_q;

  logic [31:0] inst_mem [BUF_DEPTH];
  logic [31:0] pc_mem   [BUF_DEPTH];

  logic space, req_ok, accept;
  logic push, pop, rsp_push;
  logic [31:0] push_pc, push_inst;

  assign space  = count_q < DEPTH_C;
  assign req_ok = !rst && state_q == S_REQ
                  && !flush_i && space;

  // A response is only kept when no redirect arrives with it.
  assign rsp_push = state_q == S_WAIT
                    && imem_rvalid_i && !flush_i;

`ifdef IFETCH_MISALIGN_CHECK_EN
  logic mis, mis_push, blk_q;
  logic mis_mem [BUF_DEPTH];

  assign mis        = pc_i[1:0] != 2'b00;
  assign mis_push   = req_ok && mis && !blk_q;
  assign imem_req_o = req_ok && !mis && !blk_q;
  assign push       = rsp_push || mis_push;
  assign push_pc    = mis_push ? pc_i : pend_q;
  assign push_inst  = mis_push ? 32'h0000_0013
                               : imem_rdata_i;
`else
  assign imem_req_o = req_ok;
  assign push       = rsp_push;
  assign push_pc    = pend_q;
  assign push_inst  = imem_rdata_i;
`endif

  assign accept      = imem_req_o && imem_gnt_i;
  assign stall_o     = rst || !(accept || flush_i);
  assign imem_addr_o = {pc_i[31:2], 2'b00};

  assign id_valid_o = !rst && count_q != '0;
  assign pop        = id_valid_o && id_ready_i;
  assign id_inst_o  = inst_mem[rd_q];
  assign id_pc_o    = pc_mem[rd_q];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_REQ: begin
        if (accept) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid_i) state_d = S_REQ;
        else if (flush_i) state_d = S_DISCARD;
      end
      S_DISCARD: begin
        // The late response retires the transaction even under flush.
        if (imem_rvalid_i) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_REQ;
      count_q <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) pend_q <= pc_i;
      if (flush_i) begin
        count_q <= '0;
        rd_q    <= '0;
        wr_q    <= '0;
      end else begin
        count_q <= count_q + CW'(push) - CW'(pop);
        if (push) wr_q <= wr_q + PW'(1);
        if (pop)  rd_q <= rd_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      inst_mem[wr_q] <= push_inst;
      pc_mem[wr_q]   <= push_pc;
    end
  end

`ifdef IFETCH_MISALIGN_CHECK_EN
  assign id_misalign_o = mis_mem[rd_q];

  always_ff @(posedge clk) begin
    if (!rst && push) mis_mem[wr_q] <= mis_push;
  end

  // Once a misaligned PC is trapped, hold off until redirected.
  always_ff @(posedge clk) begin
    if (rst)           blk_q <= 1'b0;
    else if (flush_i)  blk_q <= 1'b0;
    else if (mis_push) blk_q <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: bench-side PC register and memory,
// abstract queue model of the decode stream, per-cycle output compare.
module tb_ifetch_unit;

  localparam int DEPTH = 2;
  localparam logic [31:0] PC0 = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst, flush, gnt, rvalid, ready;
  logic [31:0] pc_i, rdata;
  logic stall, req, id_valid;
  logic [31:0] addr, id_inst, id_pc;
`ifdef IFETCH_MISALIGN_CHECK_EN
  logic id_mis;
`endif

  always #5 clk = ~clk;

  ifetch_unit #(.BUF_DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .pc_i(pc_i),
    .flush_i(flush),
    .stall_o(stall),
    .imem_req_o(req),
    .imem_addr_o(addr),
    .imem_gnt_i(gnt),
    .imem_rvalid_i(rvalid),
    .imem_rdata_i(rdata),
    .id_valid_o(id_valid),
    .id_ready_i(ready),
    .id_inst_o(id_inst),
`ifdef IFETCH_MISALIGN_CHECK_EN
    .id_pc_o(id_pc),
    .id_misalign_o(id_mis)
`else
    .id_pc_o(id_pc)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        mis;
  } ent_t;

  ent_t mq[$];
  ent_t log_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Model / environment state
  bit outst, kill, mblk;
  logic [31:0] m_pend, pc_reg, flush_tgt;
  bit mem_busy, ovr, acc_seen;
  int mem_cnt, lat;
  logic [31:0] mem_rd;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  function automatic logic [31:0] lpc(int i);
    return (i < log_q.size()) ? log_q[i].pc
                              : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] linst(int i);
    return (i < log_q.size()) ? log_q[i].inst
                              : 32'hFFFF_FFFF;
  endfunction

  // One clock: drive env, compare, advance model at the edge.
  task automatic step();
    bit space, mis, base, e_req, e_mpush;
    bit e_acc, e_stall, e_valid, rv;
    rvalid = mem_busy && mem_cnt == 0;
    rdata  = rvalid ? mem_rd : 32'h0;
    pc_i   = pc_reg;
    #1;
    space = mq.size() < DEPTH;
`ifdef IFETCH_MISALIGN_CHECK_EN
    mis = pc_reg[1:0] != 2'b00;
`else
    mis = 1'b0;
`endif
    base    = !rst && !outst && !flush && space;
    e_req   = base && !mis && !mblk;
    e_mpush = base && mis && !mblk;
    e_acc   = e_req && gnt;
    e_stall = rst || !(e_acc || flush);
    e_valid = !rst && mq.size() != 0;
    chk("imem_req", 32'(req), 32'(e_req));
    chk("stall", 32'(stall), 32'(e_stall));
    chk("id_valid", 32'(id_valid), 32'(e_valid));
    chk("imem_addr", addr, {pc_reg[31:2], 2'b00});
    if (e_valid) begin
      chk("id_pc", id_pc, mq[0].pc);
      chk("id_inst", id_inst, mq[0].inst);
`ifdef IFETCH_MISALIGN_CHECK_EN
      chk("id_mis", 32'(id_mis), 32'(mq[0].mis));
`endif
    end
    rv = rvalid;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      outst = 0; kill = 0; mblk = 0;
      mem_busy = 0;
      pc_reg = PC0;
    end else begin
      if (e_valid && ready) begin
        log_q.push_back(mq[0]);
        void'(mq.pop_front());
      end
      if (outst && rv) begin
        if (!kill && !flush)
          mq.push_back('{m_pend, rdata, 1'b0});
        outst = 0; kill = 0;
      end
      if (e_mpush) begin
        mq.push_back('{pc_reg, 32'h13, 1'b1});
        mblk = 1;
      end
      if (flush) begin
        mq.delete();
        mblk = 0;
        if (outst) kill = 1;
      end
      if (mem_busy) begin
        if (rv) mem_busy = 0;
        else mem_cnt--;
      end
      if (e_acc) begin
        outst = 1;
        m_pend = pc_reg;
        mem_busy = 1;
        mem_cnt = lat - 1;
        mem_rd = ovr ? 32'hDEAD_BEEF : ~pc_reg;
        ovr = 0;
        acc_seen = 1;
      end
      if (flush) pc_reg = flush_tgt;
      else if (!e_stall) pc_reg = pc_reg + 4;
    end
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_acc();
    int k;
    acc_seen = 0;
    k = 0;
    while (!acc_seen && k < 20) begin
      step();
      k++;
    end
    chk("acc_timeout", 32'(acc_seen), 32'd1);
  endtask

  initial begin
    rst = 1; flush = 0; gnt = 1; ready = 1;
    lat = 1; ovr = 0; flush_tgt = 32'h0;
    pc_reg = PC0; mem_busy = 0; mem_cnt = 0;
    outst = 0; kill = 0; mblk = 0;
    rvalid = 0; rdata = 0; pc_i = PC0;
    @(negedge clk);
    run(2);
    rst = 0;

    // Streaming fetch: one instruction per two cycles
    log_q.delete();
    run(12);
    chk("t1_pops", 32'(log_q.size()), 32'd5);
    chk("t1_pc0", lpc(0), 32'h8000_0000);
    chk("t1_inst0", linst(0), 32'h7FFF_FFFF);
    chk("t1_pc1", lpc(1), 32'h8000_0004);
    chk("t1_pc2", lpc(2), 32'h8000_0008);

    // Decode backpressure fills the buffer
    ready = 0;
    run(8);
    chk("t3_req", 32'(req), 32'd0);
    chk("t3_stall", 32'(stall), 32'd1);
    chk("t3_valid", 32'(id_valid), 32'd1);
    log_q.delete();
    ready = 1;
    run(10);
    chk("t3_pc0", lpc(0), 32'h8000_0014);
    chk("t3_pc1", lpc(1), 32'h8000_0018);
    chk("t3_pc2", lpc(2), 32'h8000_001C);

    // Interleaved pop/push
    for (int i = 0; i < 12; i++) begin
      ready = i[0];
      step();
    end
    ready = 1;

    // Redirect while a slow response is outstanding
    lat = 3;
    ovr = 1;
    wait_acc();
    flush = 1;
    flush_tgt = 32'h8000_0100;
    step();
    flush = 0;
    lat = 1;
    log_q.delete();
    run(16);
    chk("t5_pc0", lpc(0), 32'h8000_0100);
    chk("t5_inst0", linst(0), 32'h7FFF_FEFF);
    begin
      bit seen = 0;
      foreach (log_q[i])
        if (log_q[i].inst == 32'hDEAD_BEEF) seen = 1;
      chk("t5_dropped", 32'(seen), 32'd0);
    end

    // Reset while a request is outstanding
    lat = 3;
    wait_acc();
    rst = 1;
    step();
    rst = 0;
    lat = 1;
    log_q.delete();
    run(8);
    chk("t6_pc0", lpc(0), 32'h8000_0000);
    chk("t6_pc1", lpc(1), 32'h8000_0004);

`ifdef IFETCH_MISALIGN_CHECK_EN
    // Misaligned target traps, redirect resumes
    flush = 1;
    flush_tgt = 32'h8000_0002;
    step();
    flush = 0;
    log_q.delete();
    run(8);
    chk("t7_cnt", 32'(log_q.size()), 32'd1);
    chk("t7_pc", lpc(0), 32'h8000_0002);
    chk("t7_inst", linst(0), 32'h0000_0013);
    chk("t7_mis", 32'((log_q.size() > 0) && log_q[0].mis), 32'd1);
    chk("t7_req", 32'(req), 32'd0);
    flush = 1;
    flush_tgt = 32'h8000_0010;
    step();
    flush = 0;
    log_q.delete();
    run(6);
    chk("t7_res_pc", lpc(0), 32'h8000_0010);
`endif

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
